// File: rtl/watch_pkg.sv
// Shared types and helpers for the BCD watch: time record, alarm states, and the
// seven-segment decoder.
package watch_pkg;

  typedef enum logic [1:0] {IDLE, RINGING, SNOOZE} alarm_state_t;

  typedef struct packed {
    logic [3:0] hd;
    logic [3:0] ho;
    logic [3:0] md;
    logic [3:0] mo;
    logic [3:0] sd;
    logic [3:0] so;
  } bcd_time_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // {CA..CG}, active-low; non-decimal codes are blanked
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0: s = 7'h01;
      4'd1: s = 7'h4F;
      4'd2: s = 7'h12;
      4'd3: s = 7'h06;
      4'd4: s = 7'h4C;
      4'd5: s = 7'h24;
      4'd6: s = 7'h20;
      4'd7: s = 7'h0F;
      4'd8: s = 7'h00;
      4'd9: s = 7'h04;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // {hd, ho, md, mo} must be a real 24-hour HH:MM
  function automatic logic bcd_time_valid(input logic [15:0] t);
    logic [3:0] hd, ho, md, mo;
    hd = t[15:12];
    ho = t[11:8];
    md = t[7:4];
    mo = t[3:0];
    return (hd <= 4'd2) && (ho <= 4'd9) && (md <= 4'd5) && (mo <= 4'd9) &&
           !((hd == 4'd2) && (ho > 4'd3));
  endfunction

endpackage

// File: rtl/seg7_scan.sv
// Multiplexed common-anode display driver: walks one digit slot at a time and
// registers an/seg/dp together so digit and segments always match.
module seg7_scan
  import watch_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int SCAN_DIV   = 100_000
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [NUM_DIGITS-1:0][3:0] digits,
  input  logic [NUM_DIGITS-1:0]      dp_mask,
  output logic [6:0]                 seg,
  output logic                       dp,
  output logic [NUM_DIGITS-1:0]      an
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);

  logic [SW-1:0] slot;
  logic [IW-1:0] idx;
  logic [NUM_DIGITS-1:0][6:0] lane_seg;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_lane
    assign lane_seg[i] = bcd_to_seg(digits[i]);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      slot <= '0;
      idx  <= '0;
      seg  <= SEG_BLANK;
      dp   <= 1'b1;
      an   <= '1;
    end else begin
      if (slot == SW'(SCAN_DIV - 1)) begin
        slot <= '0;
        idx  <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
        slot <= slot + 1'b1;
      end
      seg <= lane_seg[idx];
      dp  <= ~dp_mask[idx];
      an  <= ~(NUM_DIGITS'(1) << idx);
    end
  end

endmodule

// File: rtl/watch_alarm_bcd.sv
// 24-hour BCD watch with validated load, alarm (ring timeout + snooze) and a
// multiplexed 4/6-digit seven-segment display.
module watch_alarm_bcd
  import watch_pkg::*;
#(
  parameter int TICK_DIV   = 100_000_000,
  parameter int SCAN_DIV   = 100_000,
  parameter int NUM_DIGITS = 6,
  parameter int SNOOZE_S   = 300,
  parameter int RING_S     = 60
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  load,
  input  logic [15:0]           time_init,
  input  logic                  alarm_wr,
  input  logic [15:0]           alarm_init,
  input  logic                  alarm_en,
  input  logic                  snooze,
  input  logic                  alarm_off,
  output logic [23:0]           time_now,
  output logic                  sec_tick,
  output logic                  alarm_active,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] an
);

  localparam int PW      = $clog2(TICK_DIV);
  localparam int CNT_MAX = (SNOOZE_S > RING_S) ? SNOOZE_S : RING_S;
  localparam int CW      = ($clog2(CNT_MAX + 1) > 9) ? $clog2(CNT_MAX + 1) : 9;

  logic [PW-1:0] presc;
  bcd_time_t     tnow, t_inc;
  logic [15:0]   alarm_reg;
  alarm_state_t  state;
  logic [CW-1:0] rcnt;
  logic          wrap, load_ok, alarm_ok, alarm_hit;

  assign wrap      = (presc == PW'(TICK_DIV - 1));
  assign load_ok   = load & bcd_time_valid(time_init);
  assign alarm_ok  = alarm_wr & bcd_time_valid(alarm_init);
  assign alarm_hit = alarm_en & sec_tick & (tnow.sd == 4'd0) & (tnow.so == 4'd0) &
                     ({tnow.hd, tnow.ho, tnow.md, tnow.mo} == alarm_reg);
  assign time_now  = tnow;

  // Ripple-carry through the BCD fields, 23:59:59 wraps to 00:00:00
  always_comb begin
    t_inc = tnow;
    if (tnow.so != 4'd9) t_inc.so = tnow.so + 1'b1;
    else begin
      t_inc.so = 4'd0;
      if (tnow.sd != 4'd5) t_inc.sd = tnow.sd + 1'b1;
      else begin
        t_inc.sd = 4'd0;
        if (tnow.mo != 4'd9) t_inc.mo = tnow.mo + 1'b1;
        else begin
          t_inc.mo = 4'd0;
          if (tnow.md != 4'd5) t_inc.md = tnow.md + 1'b1;
          else begin
            t_inc.md = 4'd0;
            if (tnow.hd == 4'd2 && tnow.ho == 4'd3) begin
              t_inc.hd = 4'd0;
              t_inc.ho = 4'd0;
            end else if (tnow.ho == 4'd9) begin
              t_inc.ho = 4'd0;
              t_inc.hd = tnow.hd + 1'b1;
            end else begin
              t_inc.ho = tnow.ho + 1'b1;
            end
          end
        end
      end
    end
  end

  // A valid load beats a same-cycle prescaler wrap and suppresses that tick
  always_ff @(posedge clk) begin
    if (!rstn) begin
      presc    <= '0;
      tnow     <= '0;
      sec_tick <= 1'b0;
    end else if (load_ok) begin
      presc    <= '0;
      tnow     <= bcd_time_t'({time_init, 8'h00});
      sec_tick <= 1'b0;
    end else if (wrap) begin
      presc    <= '0;
      tnow     <= t_inc;
      sec_tick <= 1'b1;
    end else begin
      presc    <= presc + 1'b1;
      sec_tick <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn)         alarm_reg <= '0;
    else if (alarm_ok) alarm_reg <= alarm_init;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state        <= IDLE;
      rcnt         <= '0;
      alarm_active <= 1'b0;
    end else if (!alarm_en || load_ok) begin
      state        <= IDLE;
      alarm_active <= 1'b0;
    end else begin
      case (state)
        IDLE: if (alarm_hit) begin
          state        <= RINGING;
          rcnt         <= CW'(RING_S);
          alarm_active <= 1'b1;
        end
        RINGING: begin
          if (alarm_off) begin
            state        <= IDLE;
            alarm_active <= 1'b0;
          end else if (snooze) begin
            state        <= SNOOZE;
            rcnt         <= CW'(SNOOZE_S);
            alarm_active <= 1'b0;
          end else if (sec_tick) begin
            if (rcnt <= CW'(1)) begin
              state        <= IDLE;
              alarm_active <= 1'b0;
            end else begin
              rcnt <= rcnt - 1'b1;
            end
          end
        end
        SNOOZE: begin
          if (alarm_off) begin
            state <= IDLE;
          end else if (sec_tick) begin
            if (rcnt <= CW'(1)) begin
              state        <= RINGING;
              rcnt         <= CW'(RING_S);
              alarm_active <= 1'b1;
            end else begin
              rcnt <= rcnt - 1'b1;
            end
          end
        end
        default: begin
          state        <= IDLE;
          alarm_active <= 1'b0;
        end
      endcase
    end
  end

  // Display digits right-to-left; dp lights the hour-ones slot on odd seconds
  logic [23:0]                 tvec;
  logic [NUM_DIGITS-1:0][3:0]  disp;
  logic [NUM_DIGITS-1:0]       dp_mask;

  assign tvec = tnow;

  if (NUM_DIGITS == 6) begin : g_hms
    assign disp = tvec;
  end else begin : g_hm
    assign disp = tvec[23:8];
  end

  always_comb begin
    dp_mask                 = '0;
    dp_mask[NUM_DIGITS - 2] = tnow.so[0];
    dp_mask[0]              = dp_mask[0] | alarm_en;
  end

  seg7_scan #(
    .NUM_DIGITS (NUM_DIGITS),
    .SCAN_DIV   (SCAN_DIV)
  ) u_scan (
    .clk     (clk),
    .rstn    (rstn),
    .digits  (disp),
    .dp_mask (dp_mask),
    .seg     (seg),
    .dp      (dp),
    .an      (an)
  );

endmodule

// File: tb/tb_watch_alarm_bcd.sv
// Bench for watch_alarm_bcd: seconds-count reference model compared every cycle,
// directed literal checks, then randomized load/alarm/snooze traffic.
module tb_watch_alarm_bcd;
  localparam int TD = 4, SD = 2, SN = 5, RG = 3, ND = 6;

  logic clk = 0, rstn = 0, load = 0, alarm_wr = 0, alarm_en = 0, snooze = 0, alarm_off = 0;
  logic [15:0] time_init = 0, alarm_init = 0;
  logic [23:0] time_now;
  logic sec_tick, alarm_active, dp;
  logic [6:0] seg;
  logic [ND-1:0] an;

  watch_alarm_bcd #(.TICK_DIV(TD), .SCAN_DIV(SD), .NUM_DIGITS(ND), .SNOOZE_S(SN), .RING_S(RG)) dut (
    .clk(clk), .rstn(rstn), .load(load), .time_init(time_init), .alarm_wr(alarm_wr),
    .alarm_init(alarm_init), .alarm_en(alarm_en), .snooze(snooze), .alarm_off(alarm_off),
    .time_now(time_now), .sec_tick(sec_tick), .alarm_active(alarm_active),
    .seg(seg), .dp(dp), .an(an));

  always #5 clk = ~clk;

  int checks = 0, passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic bit tvalid(input logic [15:0] v);
    int hd, ho, md, mo;
    hd = v[15:12]; ho = v[11:8]; md = v[7:4]; mo = v[3:0];
    return hd <= 9 && ho <= 9 && md <= 9 && mo <= 9 && hd * 10 + ho < 24 && md * 10 + mo < 60;
  endfunction

  function automatic int bcd_min(input logic [15:0] v);
    return (v[15:12] * 10 + v[11:8]) * 60 + v[7:4] * 10 + v[3:0];
  endfunction

  function automatic logic [15:0] min_to_bcd16(input int m);
    int h, mm;
    h = m / 60; mm = m % 60;
    return {4'(h / 10), 4'(h % 10), 4'(mm / 10), 4'(mm % 10)};
  endfunction

  function automatic logic [23:0] to_bcd(input int s);
    int h, m, x;
    h = s / 3600; m = (s / 60) % 60; x = s % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
  endfunction

  // digit index 0 = seconds ones ... 5 = hours tens
  function automatic int digit_of(input int s, input int i);
    case (i)
      0: return s % 10;
      1: return (s % 60) / 10;
      2: return (s / 60) % 10;
      3: return ((s / 60) % 60) / 10;
      4: return (s / 3600) % 10;
      default: return s / 36000;
    endcase
  endfunction

  function automatic logic [6:0] segt(input int d);
    case (d)
      0: return 7'h01; 1: return 7'h4F; 2: return 7'h12; 3: return 7'h06; 4: return 7'h4C;
      5: return 7'h24; 6: return 7'h20; 7: return 7'h0F; 8: return 7'h00; 9: return 7'h04;
      default: return 7'h7F;
    endcase
  endfunction

  // ---------------- reference model (mode: 0 idle, 1 ringing, 2 snoozed) ----------------
  int m_secs, m_presc, m_tick, m_mode, m_rem, m_amin, m_sc, m_idx;
  logic [6:0] e_seg;
  logic e_dp;
  logic [ND-1:0] e_an;
  bit m_valid = 0;

  always @(posedge clk) begin
    int ptick, psecs;
    bit ld;
    if (!rstn) begin
      m_secs = 0; m_presc = 0; m_tick = 0; m_mode = 0; m_rem = 0; m_amin = 0; m_sc = 0; m_idx = 0;
      e_seg = 7'h7F; e_dp = 1; e_an = '1; m_valid = 1;
    end else begin
      e_seg = segt(digit_of(m_secs, m_idx));
      e_an  = ~(6'b1 << m_idx);
      e_dp  = !((m_idx == 4 && m_secs % 2 == 1) || (m_idx == 0 && alarm_en));
      if (m_sc == SD - 1) begin m_sc = 0; m_idx = (m_idx + 1) % ND; end
      else m_sc++;

      ld = load && tvalid(time_init);
      ptick = m_tick; psecs = m_secs;
      if (ld) begin
        m_secs = bcd_min(time_init) * 60; m_presc = 0; m_tick = 0;
      end else if (m_presc == TD - 1) begin
        m_presc = 0; m_secs = (m_secs + 1) % 86400; m_tick = 1;
      end else begin
        m_presc++; m_tick = 0;
      end

      if (!alarm_en || ld) m_mode = 0;
      else if (m_mode != 0 && alarm_off) m_mode = 0;
      else if (m_mode == 1 && snooze) begin m_mode = 2; m_rem = SN; end
      else if (ptick != 0) begin
        if (m_mode == 0) begin
          if (psecs % 60 == 0 && psecs / 60 == m_amin) begin m_mode = 1; m_rem = RG; end
        end else begin
          m_rem--;
          if (m_rem == 0) begin
            if (m_mode == 1) m_mode = 0;
            else begin m_mode = 1; m_rem = RG; end
          end
        end
      end
      if (alarm_wr && tvalid(alarm_init)) m_amin = bcd_min(alarm_init);
    end
  end

  // ---------------- per-cycle compare + tick spacing monitor ----------------
  int cyc = 0, tick_cnt = 0, last_tick = -1;
  bit gap_en = 0;

  always @(negedge clk) begin
    cyc++;
    if (m_valid) begin
      chk("time_now", time_now, to_bcd(m_secs));
      chk("sec_tick", sec_tick, m_tick);
      chk("alarm_active", alarm_active, (m_mode == 1) ? 1 : 0);
      chk("seg", seg, e_seg);
      chk("dp", dp, e_dp);
      chk("an", an, e_an);
    end
    if (sec_tick === 1'b1) tick_cnt++;
    if (!gap_en) last_tick = -1;
    else if (sec_tick === 1'b1) begin
      if (last_tick >= 0) chk("tick_gap", cyc - last_tick, TD);
      last_tick = cyc;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_time(input logic [23:0] t, input int maxc);
    int n;
    n = 0;
    while (time_now !== t && n < maxc) begin step(); n++; end
    chk("wait_time", time_now, t);
  endtask

  function automatic logic [6:0] frozen_seg(input logic [5:0] a);
    case (a)
      6'b111110: return 7'h01;
      6'b111101: return 7'h01;
      6'b111011: return 7'h4C;
      6'b110111: return 7'h06;
      6'b101111: return 7'h12;
      6'b011111: return 7'h4F;
      default:   return 7'h7F;
    endcase
  endfunction

  initial begin
    int n, base;
    bit found;
    logic [5:0] pa;

    // 1: reset, 60 ticks
    rstn = 0; step(); step();
    chk("reset_time", time_now, 24'h0); chk("reset_an", an, 6'h3F);
    chk("reset_seg", seg, 7'h7F); chk("reset_dp", dp, 1'b1);
    rstn = 1; gap_en = 1; base = tick_cnt;
    repeat (241) step();
    chk("t1_time", time_now, 24'h000100);
    chk("t1_ticks", tick_cnt - base, 60);
    gap_en = 0;

    // 2: load 23:59, wrap to midnight, then mid-count reset
    time_init = 16'h2359; load = 1; step(); load = 0;
    repeat (240) step();
    chk("t2_wrap", time_now, 24'h000000);
    repeat (30) step();
    rstn = 0; step();
    chk("t2_rst_time", time_now, 24'h0); chk("t2_rst_tick", sec_tick, 1'b0);
    chk("t2_rst_an", an, 6'h3F); chk("t2_rst_seg", seg, 7'h7F); chk("t2_rst_dp", dp, 1'b1);
    rstn = 1;

    // 3: rejected loads, then a load on the wrap cycle
    repeat (20) step();
    time_init = 16'h2500; load = 1; step();
    time_init = 16'h1960; step(); load = 0;
    chk("t3_rejected_hhmm", time_now[23:8], 16'h0000);
    n = 0;
    while (sec_tick !== 1'b1 && n < 10) begin step(); n++; end
    chk("t3_tick_seen", sec_tick, 1'b1);
    repeat (3) step();
    time_init = 16'h0815; load = 1; step(); load = 0;
    chk("t3_wrap_load", time_now, 24'h081500);
    chk("t3_wrap_notick", sec_tick, 1'b0);

    // 4: alarm at 00:01 from reset
    rstn = 0; step();
    rstn = 1; alarm_init = 16'h0001; alarm_wr = 1; alarm_en = 1; step(); alarm_wr = 0;
    wait_time(24'h000100, 300);
    chk("t4_not_yet", alarm_active, 1'b0);
    step(); chk("t4_ring", alarm_active, 1'b1);
    repeat (11) step(); chk("t4_still_ring", alarm_active, 1'b1);
    step(); chk("t4_autoclear", alarm_active, 1'b0);

    // 5: snooze, snooze+off, disable during snooze
    time_init = 16'h0000; load = 1; step(); load = 0;
    wait_time(24'h000100, 300);
    step(); chk("t5_ring", alarm_active, 1'b1);
    snooze = 1; step(); snooze = 0;
    chk("t5_snoozed", alarm_active, 1'b0);
    n = 0;
    while (alarm_active !== 1'b1 && n < 40) begin step(); n++; end
    chk("t5_snooze_len", n, 19);
    snooze = 1; alarm_off = 1; step(); snooze = 0; alarm_off = 0;
    chk("t5_off", alarm_active, 1'b0);
    repeat (40) step(); chk("t5_no_rering", alarm_active, 1'b0);
    alarm_init = 16'h0002; alarm_wr = 1; step(); alarm_wr = 0;
    wait_time(24'h000200, 400);
    step(); chk("t5_ring2", alarm_active, 1'b1);
    snooze = 1; step(); snooze = 0;
    alarm_en = 0; step(); alarm_en = 1;
    repeat (40) step(); chk("t5_disabled", alarm_active, 1'b0);

    // 6: display scan with time held at 12:34:00, then free-running to :05
    alarm_en = 0; time_init = 16'h1234; load = 1;
    pa = an; found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      if (an == 6'b101111 && pa != 6'b101111) found = 1;
      pa = an;
    end
    chk("t6_align", found, 1'b1);
    chk("t6_hold_time", time_now, 24'h123400);
    for (int i = 0; i < 12; i++) begin
      step();
      chk("t6_frozen_seg", seg, frozen_seg(an));
    end
    chk("t6_ho_even_dp", dp, 1'b1);
    repeat (5) step();
    load = 0;
    repeat (7) step();
    chk("t6_ho_an", an, 6'b101111); chk("t6_ho_seg", seg, 7'h12);
    chk("t6_ho_odd_dp", dp, 1'b0); chk("t6_time01", time_now, 24'h123401);
    step(); chk("t6_ho_odd_dp2", dp, 1'b0);
    repeat (15) step();
    chk("t6_so_an", an, 6'b111110); chk("t6_so_seg5", seg, 7'h24);
    chk("t6_time05", time_now, 24'h123405); chk("t6_so_dp", dp, 1'b1);

    // random traffic
    alarm_en = 1;
    for (int c = 0; c < 3000; c++) begin
      load = 0; alarm_wr = 0;
      if ($urandom_range(0, 999) < 4) begin
        load = 1;
        time_init = ($urandom_range(0, 3) == 0) ? 16'($urandom) : min_to_bcd16($urandom_range(0, 1439));
      end
      if ($urandom_range(0, 99) < 2) begin
        alarm_wr = 1;
        alarm_init = ($urandom_range(0, 3) != 0) ? min_to_bcd16((m_secs / 60 + 1) % 1440) : 16'($urandom);
      end
      snooze    = ($urandom_range(0, 99) < 4);
      alarm_off = ($urandom_range(0, 99) < 1);
      if ($urandom_range(0, 199) == 0) alarm_en = ~alarm_en;
      rstn = ($urandom_range(0, 999) >= 2);
      step();
    end
    load = 0; alarm_wr = 0; snooze = 0; alarm_off = 0; rstn = 1;
    step(); step();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
